// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if
//   Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline datapath. It drives the IF/ID and ID/EX fields and
//            cnt_clr, and consumes the stall/flush controls and counters.
//   slave  : hazard_ctrl_unit. It reads the pipeline fields and drives the
//            controls and counters.
//   Signals:
//     IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2 : instruction in ID
//     ID_EX_inst_opcode, ID_EX_rd            : instruction in EX
//     ID_EX_pc_sel                           : branch/jump taken in EX
//     cnt_clr                                : synchronous counter clear
//     ctr_sel, pc_write_en, if_id_write_en,
//     if_id_flush                            : pipeline controls
//     hazard_busy, stall_cnt, flush_cnt      : status and debug counters
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [6:0]                IF_ID_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic [6:0]                ID_EX_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      ID_EX_pc_sel;
  logic                      cnt_clr;
  logic                      ctr_sel;
  logic                      pc_write_en;
  logic                      if_id_write_en;
  logic                      if_id_flush;
  logic                      hazard_busy;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;

  modport master (
    output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2,
           ID_EX_inst_opcode, ID_EX_rd, ID_EX_pc_sel, cnt_clr,
    input  ctr_sel, pc_write_en, if_id_write_en, if_id_flush,
           hazard_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2,
           ID_EX_inst_opcode, ID_EX_rd, ID_EX_pc_sel, cnt_clr,
    output ctr_sel, pc_write_en, if_id_write_en, if_id_flush,
           hazard_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller. It resolves load-use hazards with a
//   one-cycle stall and taken branches/jumps with a one-cycle flush. A
//   RUN/STALL/FLUSH state register masks load-use re-detection on the
//   bubble cycle that follows each event. Saturating counters record stall
//   and flush cycles.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-high reset; forces all controls to 0
//     hz    : hazard_ctrl_unit_if.slave (pipeline fields in, controls out)
module hazard_ctrl_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_unit_if.slave  hz
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 rs1_used;
  logic                 rs2_used;
  logic                 load_use;
  logic                 stall_evt;
  logic                 flush_evt;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  // Source-register usage of the instruction sitting in ID.
  assign rs1_used = !(hz.IF_ID_inst_opcode == OP_LUI   ||
                      hz.IF_ID_inst_opcode == OP_AUIPC ||
                      hz.IF_ID_inst_opcode == OP_JAL);
  assign rs2_used =   hz.IF_ID_inst_opcode == OP_R ||
                      hz.IF_ID_inst_opcode == OP_S ||
                      hz.IF_ID_inst_opcode == OP_B;

  assign load_use = (hz.ID_EX_inst_opcode == OP_LOAD) &&
                    (hz.ID_EX_rd != '0) &&
                    (((hz.ID_EX_rd == hz.IF_ID_rs1) && rs1_used) ||
                     ((hz.ID_EX_rd == hz.IF_ID_rs2) && rs2_used));

  // Controls are combinational so the decision lands on the same edge that
  // loads the pipeline registers. In STALL/FLUSH the ID/EX stage holds a
  // bubble with ungated opcode/rd fields, so load_use is ignored there.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    hz.ctr_sel        = 1'b1;
    hz.pc_write_en    = 1'b1;
    hz.if_id_write_en = 1'b1;
    hz.if_id_flush    = 1'b0;
    stall_evt         = 1'b0;
    flush_evt         = 1'b0;
    state_d           = RUN;

    if (reset) begin
      hz.ctr_sel        = 1'b0;
      hz.pc_write_en    = 1'b0;
      hz.if_id_write_en = 1'b0;
    end else if (hz.ID_EX_pc_sel) begin
      hz.ctr_sel     = 1'b0;
      hz.if_id_flush = 1'b1;
      flush_evt      = 1'b1;
      state_d        = FLUSH;
    end else if (state_q == RUN && load_use) begin
      hz.ctr_sel        = 1'b0;
      hz.pc_write_en    = 1'b0;
      hz.if_id_write_en = 1'b0;
      stall_evt         = 1'b1;
      state_d           = STALL;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Clear wins over a same-cycle event: that event is not counted.
      if (hz.cnt_clr) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (stall_evt && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_ONE;
        if (flush_evt && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign hz.hazard_busy = (state_q != RUN);
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
